// File: rtl/reservation_station_pkg.sv
// Shared widths, tag constants, ALU op codes and station IDs for the Tomasulo reservation stations.
package reservation_station_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  localparam int unsigned ST_ADDSUB = 1;
  localparam int unsigned ST_MULT   = 2;
  localparam int unsigned ST_DIV    = 3;
endpackage

// File: rtl/reservation_station_entry.sv
// One reservation-station slot: operand storage, CDB snoop and issue-time CDB bypass.
// RS_AGE_ORDER_EN adds a saturating 2-bit age counter per slot.
module rs_entry #(
  parameter int unsigned DATA_W = reservation_station_pkg::DATA_W,
  parameter int unsigned TAG_W  = reservation_station_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_op,
  input  logic [DATA_W-1:0] wr_vj,
  input  logic [DATA_W-1:0] wr_vk,
  input  logic [TAG_W-1:0]  wr_qj,
  input  logic [TAG_W-1:0]  wr_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              free,
`ifdef RS_AGE_ORDER_EN
  input  logic              age_inc,
  output logic [1:0]        age,
`endif
  output logic              busy,
  output logic              ready,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);
  import reservation_station_pkg::*;

  logic [TAG_W-1:0] qj, qk;
  logic cdb_live, j_hit, k_hit, wj_hit, wk_hit;

  assign cdb_live = cdb_valid && (cdb_tag != TAG_W'(NO_TAG));
  assign j_hit    = cdb_live && busy && (qj == cdb_tag);
  assign k_hit    = cdb_live && busy && (qk == cdb_tag);
  assign wj_hit   = cdb_live && (wr_qj == cdb_tag);
  assign wk_hit   = cdb_live && (wr_qk == cdb_tag);
  assign ready    = busy && (qj == '0) && (qk == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      op   <= '0;
      vj   <= '0;
      vk   <= '0;
      qj   <= '0;
      qk   <= '0;
    end else if (wr_en) begin
      busy <= 1'b1;
      op   <= wr_op;
      vj   <= wj_hit ? cdb_data : wr_vj;
      qj   <= wj_hit ? '0 : wr_qj;
      vk   <= wk_hit ? cdb_data : wr_vk;
      qk   <= wk_hit ? '0 : wr_qk;
    end else begin
      if (free) busy <= 1'b0;
      if (j_hit) begin
        vj <= cdb_data;
        qj <= '0;
      end
      if (k_hit) begin
        vk <= cdb_data;
        qk <= '0;
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  always_ff @(posedge clk) begin
    if (rst) age <= '0;
    else if (wr_en) age <= '0;
    else if (age_inc && busy && (age != 2'd3)) age <= age + 2'd1;
  end
`endif
endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: free-slot encoder, dispatch selector and dispatch lock.
// RS_AGE_ORDER_EN selects the oldest ready entry instead of the lowest-index one.
module reservation_station #(
  parameter int unsigned ENTRIES    = 3,
  parameter int unsigned STATION_ID = reservation_station_pkg::ST_ADDSUB,
  parameter int unsigned DATA_W     = reservation_station_pkg::DATA_W,
  parameter int unsigned TAG_W      = reservation_station_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic [TAG_W-1:0]  issue_tag,
  output logic              is_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic [1:0]        exec_op,
  output logic [DATA_W-1:0] exec_a,
  output logic [DATA_W-1:0] exec_b,
  output logic [TAG_W-1:0]  exec_tag
);
  import reservation_station_pkg::*;

  localparam int unsigned SLOT_W = TAG_W - 2;
  localparam logic [1:0]  SID    = 2'(STATION_ID);

  logic [ENTRIES-1:0] ent_busy, ent_ready;
  logic [1:0]         ent_op [ENTRIES];
  logic [DATA_W-1:0]  ent_vj [ENTRIES];
  logic [DATA_W-1:0]  ent_vk [ENTRIES];
`ifdef RS_AGE_ORDER_EN
  logic [1:0]         ent_age [ENTRIES];
  logic [1:0]         best_age;
`endif

  logic [SLOT_W-1:0] free_slot, sel_slot, cur_slot, lock_slot;
  logic              free_found, any_ready, lock_vld, issue_acc, accept;

  assign is_full   = &ent_busy;
  assign issue_acc = issue_en && !is_full;
  assign issue_tag = {SID, free_slot};

  always_comb begin
    free_slot  = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!ent_busy[i] && !free_found) begin
        free_slot  = SLOT_W'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_slot  = '0;
    any_ready = 1'b0;
`ifdef RS_AGE_ORDER_EN
    best_age  = '0;
`endif
    for (int unsigned i = 0; i < ENTRIES; i++) begin
`ifdef RS_AGE_ORDER_EN
      if (ent_ready[i] && (!any_ready || ent_age[i] > best_age)) begin
        sel_slot  = SLOT_W'(i);
        best_age  = ent_age[i];
        any_ready = 1'b1;
      end
`else
      if (ent_ready[i] && !any_ready) begin
        sel_slot  = SLOT_W'(i);
        any_ready = 1'b1;
      end
`endif
    end
  end

  // A stalled presentation stays pinned to its slot; a locked entry stays ready
  // because its tags are already zero and the CDB never matches tag zero.
  assign cur_slot   = lock_vld ? lock_slot : sel_slot;
  assign exec_valid = lock_vld || any_ready;
  assign accept     = exec_valid && exec_ready;

  always_comb begin
    exec_op  = '0;
    exec_a   = '0;
    exec_b   = '0;
    exec_tag = '0;
    if (exec_valid) begin
      exec_tag = {SID, cur_slot};
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (cur_slot == SLOT_W'(i)) begin
          exec_op = ent_op[i];
          exec_a  = ent_vj[i];
          exec_b  = ent_vk[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld  <= 1'b0;
      lock_slot <= '0;
    end else if (accept) begin
      lock_vld  <= 1'b0;
    end else if (exec_valid) begin
      lock_vld  <= 1'b1;
      lock_slot <= cur_slot;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    rs_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (issue_acc && (free_slot == SLOT_W'(g))),
      .wr_op     (issue_op),
      .wr_vj     (issue_vj),
      .wr_vk     (issue_vk),
      .wr_qj     (issue_qj),
      .wr_qk     (issue_qk),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .free      (accept && (cur_slot == SLOT_W'(g))),
`ifdef RS_AGE_ORDER_EN
      .age_inc   (issue_acc),
      .age       (ent_age[g]),
`endif
      .busy      (ent_busy[g]),
      .ready     (ent_ready[g]),
      .op        (ent_op[g]),
      .vj        (ent_vj[g]),
      .vk        (ent_vk[g])
    );
  end
endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station (default build, ENTRIES=3, STATION_ID=1).
module tb_reservation_station;
  logic        clk = 1'b0;
  logic        rst, issue_en, cdb_valid, exec_ready;
  logic [1:0]  issue_op;
  logic [31:0] issue_vj, issue_vk, cdb_data;
  logic [3:0]  issue_qj, issue_qk, cdb_tag;
  logic [3:0]  issue_tag, exec_tag;
  logic        is_full, exec_valid;
  logic [1:0]  exec_op;
  logic [31:0] exec_a, exec_b;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  reservation_station #(
    .ENTRIES(3), .STATION_ID(1), .DATA_W(32), .TAG_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_en(issue_en), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_tag(issue_tag), .is_full(is_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_op(exec_op),
    .exec_a(exec_a), .exec_b(exec_b), .exec_tag(exec_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every handshake observed ahead of the edge must match the next expected dispatch.
  always @(negedge clk) begin
    if (!rst && exec_valid && exec_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL dispatch_unexpected got op=%0d a=%h b=%h tag=%h want none",
                 exec_op, exec_a, exec_b, exec_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({exec_op, exec_a, exec_b, exec_tag} !== e)
          $display("FAIL dispatch got op=%0d a=%h b=%h tag=%h want op=%0d a=%h b=%h tag=%h",
                   exec_op, exec_a, exec_b, exec_tag, e.op, e.a, e.b, e.tag);
        else passes++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_en = 0; issue_op = 0; issue_vj = 0; issue_vk = 0; issue_qj = 0; issue_qk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic drive_issue(input logic [1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [3:0] qj, input logic [3:0] qk);
    issue_en = 1; issue_op = op; issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
  endtask

  task automatic test_reset();
    rst = 1; exec_ready = 0; idle_inputs();
    step(); step();
    rst = 0;
    checks++; if (is_full !== 1'b0) $display("FAIL reset_full got %b want 0", is_full); else passes++;
    checks++; if (exec_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", exec_valid); else passes++;
    checks++;
    if ({exec_op, exec_a, exec_b, exec_tag} !== '0)
      $display("FAIL reset_exec got op=%0d a=%h b=%h tag=%h want all 0", exec_op, exec_a, exec_b, exec_tag);
    else passes++;
    checks++; if (issue_tag !== 4'h4) $display("FAIL reset_issue_tag got %h want 4", issue_tag); else passes++;
  endtask

  task automatic test_basic();
    drive_issue(2'd0, 32'd5, 32'd7, 4'h0, 4'h0);
    step();
    idle_inputs();
    checks++;
    if (exec_valid !== 1'b1 || exec_a !== 32'd5 || exec_b !== 32'd7 || exec_tag !== 4'h4)
      $display("FAIL basic_present got v=%b a=%h b=%h tag=%h want v=1 a=5 b=7 tag=4",
               exec_valid, exec_a, exec_b, exec_tag);
    else passes++;
    sb.push_back('{op: 2'd0, a: 32'd5, b: 32'd7, tag: 4'h4});
    exec_ready = 1;
    step();
    exec_ready = 0;
    checks++; if (exec_valid !== 1'b0) $display("FAIL basic_after_accept got %b want 0", exec_valid); else passes++;
    checks++; if (issue_tag !== 4'h4) $display("FAIL basic_issue_tag got %h want 4", issue_tag); else passes++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (issue_tag !== 4'(4 + i)) $display("FAIL full_issue_tag%0d got %h want %h", i, issue_tag, 4'(4 + i));
      else passes++;
      drive_issue(2'd1, 32'h100 + i, 32'h200 + i, 4'h9, 4'h0);
      step();
    end
    idle_inputs();
    checks++; if (is_full !== 1'b1) $display("FAIL full_flag got %b want 1", is_full); else passes++;
    drive_issue(2'd3, 32'hBAD, 32'hBAD, 4'h0, 4'h0);
    step();
    idle_inputs();
    checks++;
    if (is_full !== 1'b1 || exec_valid !== 1'b0)
      $display("FAIL full_ignored got full=%b valid=%b want full=1 valid=0", is_full, exec_valid);
    else passes++;
    cdb_valid = 1; cdb_tag = 4'h9; cdb_data = 32'h99;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++)
      sb.push_back('{op: 2'd1, a: 32'h99, b: 32'h200 + i, tag: 4'(4 + i)});
    checks++;
    if (exec_valid !== 1'b1 || exec_tag !== 4'h4)
      $display("FAIL full_wake got v=%b tag=%h want v=1 tag=4", exec_valid, exec_tag);
    else passes++;
    exec_ready = 1;
    checks++; if (is_full !== 1'b1) $display("FAIL full_same_cycle got %b want 1", is_full); else passes++;
    step();
    checks++; if (is_full !== 1'b0) $display("FAIL full_drop got %b want 0", is_full); else passes++;
    checks++; if (issue_tag !== 4'h4) $display("FAIL full_freed_tag got %h want 4", issue_tag); else passes++;
    step(); step();
    exec_ready = 0;
    checks++; if (exec_valid !== 1'b0) $display("FAIL full_drained got %b want 0", exec_valid); else passes++;
  endtask

  task automatic test_cdb_k();
    drive_issue(2'd2, 32'h11, 32'h0, 4'h0, 4'hA);
    step();
    cdb_valid = 1; cdb_tag = 4'h0; cdb_data = 32'hDEAD;
    issue_en = 0;
    step();
    checks++; if (exec_valid !== 1'b0) $display("FAIL cdbk_wait got %b want 0", exec_valid); else passes++;
    cdb_valid = 1; cdb_tag = 4'hA; cdb_data = 32'h1234;
    sb.push_back('{op: 2'd2, a: 32'h11, b: 32'h1234, tag: 4'h4});
    step();
    idle_inputs();
    checks++;
    if (exec_valid !== 1'b1 || exec_b !== 32'h1234 || exec_a !== 32'h11)
      $display("FAIL cdbk_capture got v=%b a=%h b=%h want v=1 a=11 b=1234", exec_valid, exec_a, exec_b);
    else passes++;
    exec_ready = 1;
    step();
    exec_ready = 0;
  endtask

  task automatic test_bypass();
    drive_issue(2'd3, 32'hFFFF, 32'h22, 4'hB, 4'h0);
    cdb_valid = 1; cdb_tag = 4'hB; cdb_data = 32'h55;
    step();
    idle_inputs();
    checks++;
    if (exec_valid !== 1'b1 || exec_a !== 32'h55)
      $display("FAIL bypass got v=%b a=%h want v=1 a=55", exec_valid, exec_a);
    else passes++;
    sb.push_back('{op: 2'd3, a: 32'h55, b: 32'h22, tag: 4'h4});
    exec_ready = 1;
    step();
    exec_ready = 0;
  endtask

  task automatic test_lock();
    drive_issue(2'd0, 32'h0, 32'h40, 4'hC, 4'h0);
    step();
    drive_issue(2'd1, 32'h31, 32'h32, 4'h0, 4'h0);
    step();
    idle_inputs();
    checks++;
    if (exec_valid !== 1'b1 || exec_tag !== 4'h5)
      $display("FAIL lock_first got v=%b tag=%h want v=1 tag=5", exec_valid, exec_tag);
    else passes++;
    cdb_valid = 1; cdb_tag = 4'hC; cdb_data = 32'h77;
    step();
    idle_inputs();
    step();
    checks++;
    if (exec_tag !== 4'h5 || exec_a !== 32'h31 || exec_b !== 32'h32)
      $display("FAIL lock_hold got tag=%h a=%h b=%h want tag=5 a=31 b=32", exec_tag, exec_a, exec_b);
    else passes++;
    sb.push_back('{op: 2'd1, a: 32'h31, b: 32'h32, tag: 4'h5});
    sb.push_back('{op: 2'd0, a: 32'h77, b: 32'h40, tag: 4'h4});
    exec_ready = 1;
    step(); step();
    exec_ready = 0;
    checks++; if (exec_valid !== 1'b0) $display("FAIL lock_drained got %b want 0", exec_valid); else passes++;
  endtask

  task automatic test_reset_mid();
    drive_issue(2'd1, 32'hAA, 32'hBB, 4'h0, 4'h0);
    step();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (exec_valid !== 1'b0 || is_full !== 1'b0 || issue_tag !== 4'h4)
      $display("FAIL reset_mid got v=%b full=%b tag=%h want v=0 full=0 tag=4", exec_valid, is_full, issue_tag);
    else passes++;
    step();
    checks++; if (exec_valid !== 1'b0) $display("FAIL reset_mid_stay got %b want 0", exec_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_cdb_k();
    test_bypass();
    test_lock();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
